// File: rtl/prbs_pkg.sv
// Shared PRBS5 definitions (x^5 + x^3 + 1) used by the pattern generator and checker.
package prbs_pkg;

    typedef enum logic {
        SEARCH,
        LOCKED
    } prbs_state_e;

    localparam int unsigned PRBS5_LEN    = 5;
    localparam int unsigned PRBS5_PERIOD = 31;
    localparam int unsigned PRBS5_TAP_A  = 4;
    localparam int unsigned PRBS5_TAP_B  = 2;

    // hist[k] is the bit from k+1 samples ago; returns the next bit of the sequence.
    function automatic logic prbs5_predict(input logic [PRBS5_LEN-1:0] hist);
        return hist[PRBS5_TAP_A] ^ hist[PRBS5_TAP_B];
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear wins over increment.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (inc && (r_q != '1)) begin
            r_q <= r_q + W'(1);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/prbs5_checker.sv
// Self-synchronising PRBS5 checker: locks onto the received stream, then free-runs a
// local reference and reports per-bit errors, error/bit counts and lock status.
module prbs5_checker
    import prbs_pkg::*;
#(
    parameter int unsigned LOCK_CNT    = 31,
    parameter int unsigned WIN_LEN     = 31,
    parameter int unsigned UNLOCK_ERRS = 8,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_data,
    input  logic             i_clr,
    output logic             o_lock,
    output logic             o_err,
    output logic [CNT_W-1:0] o_err_cnt,
    output logic [CNT_W-1:0] o_bit_cnt
);

    localparam int unsigned WinW = $clog2(WIN_LEN + 1);

    localparam logic [2:0]      FillDone = 3'(PRBS5_LEN);
    localparam logic [7:0]      LockCntB = 8'(LOCK_CNT);
    localparam logic [WinW-1:0] WinLenB  = WinW'(WIN_LEN);
    localparam logic [WinW-1:0] UnlockB  = WinW'(UNLOCK_ERRS);

    prbs_state_e              r_state, w_state_d;
    logic [PRBS5_LEN-1:0]     r_hist, w_hist_d;
    logic [2:0]               r_fill, w_fill_d;
    logic [7:0]               r_match, w_match_d, w_match_inc;
    logic [WinW-1:0]          r_win_cnt, w_win_cnt_d, w_win_inc;
    logic [WinW-1:0]          r_win_err, w_win_err_d, w_win_err_inc;
    logic                     r_err, w_err_d;
    logic                     w_p, w_mis, w_bit_inc, w_err_inc;

    assign w_p           = prbs5_predict(r_hist);
    assign w_mis         = (i_data != w_p);
    assign w_match_inc   = r_match + 8'd1;
    assign w_win_inc     = r_win_cnt + WinW'(1);
    assign w_win_err_inc = r_win_err + WinW'(1);

    always_comb begin
        w_state_d   = r_state;
        w_hist_d    = r_hist;
        w_fill_d    = r_fill;
        w_match_d   = r_match;
        w_win_cnt_d = r_win_cnt;
        w_win_err_d = r_win_err;
        w_err_d     = 1'b0;
        w_bit_inc   = 1'b0;
        w_err_inc   = 1'b0;

        if (i_en) begin
            unique case (r_state)
                SEARCH: begin
                    w_hist_d = {r_hist[PRBS5_LEN-2:0], i_data};
                    if (r_fill != FillDone) begin
                        w_fill_d = r_fill + 3'd1;
                    end else if (!w_mis && (r_hist != '0)) begin
                        w_match_d = w_match_inc;
                        if (w_match_inc == LockCntB) begin
                            w_state_d   = LOCKED;
                            w_win_cnt_d = '0;
                            w_win_err_d = '0;
                        end
                    end else begin
                        w_match_d = '0;
                    end
                end
                LOCKED: begin
                    // Reference free-runs; received bits are only compared, never stored.
                    w_hist_d    = {r_hist[PRBS5_LEN-2:0], w_p};
                    w_bit_inc   = 1'b1;
                    w_win_cnt_d = w_win_inc;
                    if (w_mis) begin
                        w_err_d     = 1'b1;
                        w_err_inc   = 1'b1;
                        w_win_err_d = w_win_err_inc;
                    end
                    if (w_win_inc == WinLenB) begin
                        w_win_cnt_d = '0;
                        w_win_err_d = '0;
                    end
                    if (w_mis && (w_win_err_inc == UnlockB)) begin
                        w_state_d = SEARCH;
                        w_fill_d  = '0;
                        w_match_d = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= SEARCH;
            r_hist    <= '0;
            r_fill    <= '0;
            r_match   <= '0;
            r_win_cnt <= '0;
            r_win_err <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_hist    <= w_hist_d;
            r_fill    <= w_fill_d;
            r_match   <= w_match_d;
            r_win_cnt <= w_win_cnt_d;
            r_win_err <= w_win_err_d;
            r_err     <= w_err_d;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_err_cnt (
        .clk(clk),
        .rst(rst),
        .clr(i_clr),
        .inc(w_err_inc),
        .q  (o_err_cnt)
    );

    sat_counter #(
        .W(CNT_W)
    ) u_bit_cnt (
        .clk(clk),
        .rst(rst),
        .clr(i_clr),
        .inc(w_bit_inc),
        .q  (o_bit_cnt)
    );

    assign o_lock = (r_state == LOCKED);
    assign o_err  = r_err;

endmodule
